// File: rtl/fifo_rd_pack32_pkg.sv
// Shared constants and lane-placement helper for the narrow-to-wide FIFO read packer.
package fifo_rd_pack32_pkg;

  localparam int unsigned DEF_IN_WIDTH = 8;
  localparam int unsigned DEF_RATIO    = 4;
  localparam int unsigned WORD_W       = DEF_IN_WIDTH * DEF_RATIO;

  // Byte number idx (0 = first read) maps to this lane of the packed word.
  function automatic int unsigned lane_idx(int unsigned idx, int unsigned ratio, bit msb_first);
    return msb_first ? (ratio - 1 - idx) : idx;
  endfunction

endpackage

// File: rtl/fifo_rd_pack32_if.sv
// FIFO read port plus packed-word valid/ready stream, seen from the packer (master) side.
interface fifo_rd_pack32_if
  import fifo_rd_pack32_pkg::*;
#(
  parameter int unsigned IN_WIDTH = DEF_IN_WIDTH,
  parameter int unsigned RATIO    = DEF_RATIO
);

  logic                         fifo_rd_en;
  logic                         fifo_rd_empty;
  logic [IN_WIDTH-1:0]          fifo_rd_data;
  logic [IN_WIDTH*RATIO-1:0]    m_data;
  logic                         m_valid;
  logic                         m_ready;
  logic [15:0]                  word_cnt;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_empty,
    input  fifo_rd_data,
    output m_data,
    output m_valid,
    input  m_ready,
    output word_cnt
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_empty,
    output fifo_rd_data,
    input  m_data,
    input  m_valid,
    output m_ready,
    input  word_cnt
  );

endinterface

// File: rtl/fifo_rd_lat_pipe.sv
// Tracks reads in flight through a fixed-latency FIFO read path.
module fifo_rd_lat_pipe #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned CNT_W   = $clog2(LATENCY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue,
  output logic             land,
  output logic [CNT_W-1:0] inflight
);

  logic [LATENCY-1:0] pipe_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= issue;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign land = pipe_q[LATENCY-1];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + CNT_W'(pipe_q[i]);
    end
  end

endmodule

// File: rtl/fifo_rd_pack32.sv
// Drains bytes from a narrow FIFO read port and re-packs RATIO of them into one wide
// word on a valid/ready stream, never issuing more reads than assembly can absorb.
module fifo_rd_pack32
  import fifo_rd_pack32_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = DEF_IN_WIDTH,
  parameter int unsigned RATIO      = DEF_RATIO,
  parameter int unsigned RD_LATENCY = 1,
  parameter bit          MSB_FIRST  = 1'b0
) (
  input logic              rd_clk,
  input logic              rd_rst_n,
  fifo_rd_pack32_if.master bus
);

  localparam int unsigned WordW = IN_WIDTH * RATIO;
  localparam int unsigned CntW  = $clog2(RATIO + 1);
  localparam int unsigned InfW  = $clog2(RD_LATENCY + 1);
  localparam logic [CntW-1:0] RatioC = CntW'(RATIO);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WordW-1:0] asm_q, asm_d, out_word;
  logic [WordW-1:0] m_data_q;
  logic             m_valid_q;
  logic [15:0]      word_cnt_q;
  logic             land, complete, xfer, rd_en;
  logic [InfW-1:0]  inflight;
  int unsigned      commit, wr_pos;

  fifo_rd_lat_pipe #(
    .LATENCY (RD_LATENCY),
    .CNT_W   (InfW)
  ) u_lat_pipe (
    .clk      (rd_clk),
    .rst_n    (rd_rst_n),
    .issue    (rd_en),
    .land     (land),
    .inflight (inflight)
  );

  always_comb begin
    complete = (cnt_q == RatioC) || (land && (cnt_q == RatioC - CntW'(1)));
    xfer     = complete && (!m_valid_q || bus.m_ready);
    // Bytes committed after this cycle's transfer; a new read must still fit.
    commit   = 32'(cnt_q) + 32'(inflight) - (xfer ? RATIO : 32'd0);
    rd_en    = rd_rst_n && !bus.fifo_rd_empty && (commit < RATIO);

    wr_pos = (cnt_q == RatioC) ? 32'd0 : 32'(cnt_q);
    asm_d  = asm_q;
    if (land) begin
      asm_d[lane_idx(wr_pos, RATIO, MSB_FIRST) * IN_WIDTH +: IN_WIDTH] = bus.fifo_rd_data;
    end
    // A byte landing while already full belongs to the next word, not this one.
    out_word = (cnt_q == RatioC) ? asm_q : asm_d;

    if (xfer) begin
      cnt_d = (cnt_q == RatioC && land) ? CntW'(1) : '0;
    end else begin
      cnt_d = cnt_q + CntW'(land);
    end
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      cnt_q      <= '0;
      asm_q      <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
      if (xfer) begin
        m_valid_q <= 1'b1;
        m_data_q  <= out_word;
      end else if (bus.m_ready) begin
        m_valid_q <= 1'b0;
      end
      if (m_valid_q && bus.m_ready) begin
        word_cnt_q <= word_cnt_q + 16'd1;
      end
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_data     = m_data_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_fifo_rd_pack32.sv
// Runs two packers (latency 1 LSB-first, latency 2 MSB-first) against a queue-based FIFO and
// word model under directed and random stimulus.
module tb_fifo_rd_pack32;
  import fifo_rd_pack32_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic        en[2], empty[2], valid[2], ready[2];
  logic [7:0]  rdata[2];
  logic [31:0] mdata[2];
  logic [15:0] wcnt[2];

  fifo_rd_pack32_if #(.IN_WIDTH(8), .RATIO(4)) bus0 ();
  fifo_rd_pack32_if #(.IN_WIDTH(8), .RATIO(4)) bus1 ();

  fifo_rd_pack32 #(.IN_WIDTH(8), .RATIO(4), .RD_LATENCY(1), .MSB_FIRST(1'b0)) dut0 (
    .rd_clk   (clk),
    .rd_rst_n (rst_n),
    .bus      (bus0)
  );

  fifo_rd_pack32 #(.IN_WIDTH(8), .RATIO(4), .RD_LATENCY(2), .MSB_FIRST(1'b1)) dut1 (
    .rd_clk   (clk),
    .rd_rst_n (rst_n),
    .bus      (bus1)
  );

  assign bus0.fifo_rd_empty = empty[0];
  assign bus0.fifo_rd_data  = rdata[0];
  assign bus0.m_ready       = ready[0];
  assign en[0]              = bus0.fifo_rd_en;
  assign valid[0]           = bus0.m_valid;
  assign mdata[0]           = bus0.m_data;
  assign wcnt[0]            = bus0.word_cnt;
  assign bus1.fifo_rd_empty = empty[1];
  assign bus1.fifo_rd_data  = rdata[1];
  assign bus1.m_ready       = ready[1];
  assign en[1]              = bus1.fifo_rd_en;
  assign valid[1]           = bus1.m_valid;
  assign mdata[1]           = bus1.m_data;
  assign wcnt[1]            = bus1.word_cnt;

  // Reference state: FIFO contents, bytes read so far, complete words owed downstream.
  logic [7:0]  fq[2][$];
  logic [7:0]  part[2][$];
  logic [7:0]  hist[2][$];
  logic [31:0] expw[2][$];
  logic [31:0] words_seen[2][$];
  int          got_cyc[2][$];
  int          en_cyc[2][$];
  int          acc[2], popped[2];
  bit          hold_pend[2];
  logic [31:0] hold_data[2];

  int cyc, rst_seen, cur_ch, rdy_mode;
  bit rst_req, tog, rnd_empty, chk_release;
  int nvec, nmis;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    nvec++;
    if (obs !== exp_v) begin
      nmis++;
      $display("FAIL %s ch%0d cycle %0d: got 0x%0h, expected 0x%0h", tag, cur_ch, cyc, obs, exp_v);
    end
  endtask

  task automatic sample(input int ch);
    logic [7:0]  b;
    logic [31:0] w;
    int          lane;
    cur_ch = ch;
    if (!rst_n) begin
      check("rst_rd_en", en[ch], 0);
      if (rst_seen > 0) begin
        check("rst_m_valid", valid[ch], 0);
        check("rst_word_cnt", wcnt[ch], 0);
        check("rst_m_data", mdata[ch], 0);
      end
      part[ch].delete();
      expw[ch].delete();
      acc[ch]       = 0;
      popped[ch]    = 0;
      hold_pend[ch] = 1'b0;
      hist[ch].push_back(8'($urandom));
      return;
    end
    if (chk_release) check("release_rd_en", en[ch], 1);
    check("word_cnt", wcnt[ch], 64'(16'(acc[ch])));
    b = 8'($urandom);
    if (en[ch]) begin
      check("rd_en_while_empty", empty[ch], 0);
      en_cyc[ch].push_back(cyc);
      if (fq[ch].size() > 0) begin
        b = fq[ch].pop_front();
        popped[ch]++;
        part[ch].push_back(b);
        if (part[ch].size() == 4) begin
          w = '0;
          for (int k = 0; k < 4; k++) begin
            lane = (ch == 1) ? 3 - k : k;
            w[8*lane +: 8] = part[ch][k];
          end
          expw[ch].push_back(w);
          part[ch].delete();
        end
      end
    end
    hist[ch].push_back(b);
    if (hist[ch].size() > 8) void'(hist[ch].pop_front());
    if (hold_pend[ch]) begin
      check("hold_valid", valid[ch], 1);
      check("hold_data", mdata[ch], hold_data[ch]);
    end
    if (valid[ch]) begin
      if (expw[ch].size() == 0) begin
        check("spurious_valid", valid[ch], 0);
      end else if (ready[ch]) begin
        check("word", mdata[ch], expw[ch].pop_front());
        acc[ch]++;
        words_seen[ch].push_back(mdata[ch]);
        got_cyc[ch].push_back(cyc);
      end
    end
    hold_pend[ch] = valid[ch] && !ready[ch];
    hold_data[ch] = mdata[ch];
    // Output register plus assembly never hold more than two words of bytes.
    check("capacity", 64'((popped[ch] - 4 * acc[ch]) <= 8), 1);
  endtask

  task automatic step();
    int lat;
    @(negedge clk);
    cyc++;
    rst_n = !rst_req;
    for (int ch = 0; ch < 2; ch++) begin
      lat = ch + 1;
      empty[ch] = (fq[ch].size() == 0) || (tog && cyc[0]) || (rnd_empty && $urandom_range(3) == 0);
      ready[ch] = (rdy_mode == 2) ? 1'($urandom_range(1)) : (rdy_mode == 1);
      rdata[ch] = (hist[ch].size() >= lat) ? hist[ch][hist[ch].size() - lat] : 8'h00;
    end
    #1;
    for (int ch = 0; ch < 2; ch++) sample(ch);
    rst_seen = rst_n ? 0 : rst_seen + 1;
  endtask

  task automatic clear_logs();
    for (int ch = 0; ch < 2; ch++) begin
      words_seen[ch].delete();
      got_cyc[ch].delete();
      en_cyc[ch].delete();
    end
  endtask

  task automatic do_reset(input int n);
    for (int ch = 0; ch < 2; ch++) fq[ch].delete();
    rst_req = 1'b1;
    repeat (n) step();
    rst_req = 1'b0;
    clear_logs();
  endtask

  task automatic load(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fq[0].push_back(base + 8'(i));
      fq[1].push_back(base + 8'(i));
    end
  endtask

  logic [31:0] w0, w1;

  initial begin
    nvec = 0; nmis = 0; cyc = 0; rst_seen = 0;
    rst_n = 1'b0; rst_req = 1'b1; tog = 1'b0; rnd_empty = 1'b0; chk_release = 1'b0;
    rdy_mode = 1;
    for (int ch = 0; ch < 2; ch++) begin
      empty[ch] = 1'b1; ready[ch] = 1'b0; rdata[ch] = '0;
      acc[ch] = 0; popped[ch] = 0; hold_pend[ch] = 1'b0; hold_data[ch] = '0;
    end

    // Reset held with a non-empty FIFO, then streaming of bytes 01..08.
    load(8'h01, 8);
    repeat (3) step();
    rst_req = 1'b0;
    clear_logs();
    chk_release = 1'b1;
    step();
    chk_release = 1'b0;
    repeat (30) step();
    for (int ch = 0; ch < 2; ch++) begin
      cur_ch = ch;
      w0 = (ch == 0) ? 32'h04030201 : 32'h01020304;
      w1 = (ch == 0) ? 32'h08070605 : 32'h05060708;
      check("stream_words", words_seen[ch].size(), 2);
      check("stream_w0", (words_seen[ch].size() > 0) ? words_seen[ch][0] : 'x, w0);
      check("stream_w1", (words_seen[ch].size() > 1) ? words_seen[ch][1] : 'x, w1);
      check("stream_word_cnt", wcnt[ch], 2);
      check("stream_reads", en_cyc[ch].size(), 8);
      if (en_cyc[ch].size() > 0 && got_cyc[ch].size() > 0)
        check("first_latency", got_cyc[ch][0] - en_cyc[ch][0], ch + 1 + 4);
    end
    cur_ch = 0;
    if (en_cyc[0].size() == 8) check("reads_back_to_back", en_cyc[0][7] - en_cyc[0][0], 7);
    if (got_cyc[0].size() == 2) check("word_spacing", got_cyc[0][1] - got_cyc[0][0], 4);

    // Backpressure with 12 bytes available.
    do_reset(2);
    load(8'h01, 12);
    rdy_mode = 0;
    repeat (25) step();
    for (int ch = 0; ch < 2; ch++) begin
      cur_ch = ch;
      check("bp_reads", popped[ch], 8);
      check("bp_valid", valid[ch], 1);
      check("bp_data", mdata[ch], (ch == 0) ? 32'h04030201 : 32'h01020304);
    end
    rdy_mode = 1;
    repeat (25) step();
    for (int ch = 0; ch < 2; ch++) begin
      cur_ch = ch;
      check("bp_drain_words", acc[ch], 3);
      check("bp_left_over", expw[ch].size() + part[ch].size() + fq[ch].size(), 0);
    end

    // Empty flag toggling every cycle.
    do_reset(1);
    load(8'h01, 8);
    tog = 1'b1;
    repeat (40) step();
    tog = 1'b0;
    for (int ch = 0; ch < 2; ch++) begin
      cur_ch = ch;
      check("toggle_words", acc[ch], 2);
    end

    // Reset after two reads: only fresh bytes may form the next word.
    do_reset(1);
    load(8'h01, 8);
    for (int i = 0; i < 10 && popped[0] < 2; i++) step();
    cur_ch = 0;
    check("mid_wait", popped[0], 2);
    do_reset(1);
    load(8'hA1, 4);
    repeat (20) step();
    for (int ch = 0; ch < 2; ch++) begin
      cur_ch = ch;
      check("mid_words", words_seen[ch].size(), 1);
      check("mid_w0", (words_seen[ch].size() > 0) ? words_seen[ch][0] : 'x,
            (ch == 0) ? 32'hA4A3A2A1 : 32'hA1A2A3A4);
    end

    // Random traffic, random backpressure, random empty gaps and occasional resets.
    rdy_mode = 2;
    rnd_empty = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(2) == 0 && fq[0].size() < 64) begin
        w0[7:0] = 8'($urandom);
        fq[0].push_back(w0[7:0]);
        fq[1].push_back(w0[7:0]);
      end
      if ($urandom_range(599) == 0) do_reset(1 + $urandom_range(2));
      else step();
    end
    rdy_mode = 1;
    rnd_empty = 1'b0;
    repeat (80) step();
    for (int ch = 0; ch < 2; ch++) begin
      cur_ch = ch;
      check("drain_words_owed", expw[ch].size(), 0);
      check("drain_fifo", fq[ch].size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
